// File: rtl/axis_stream_checker_if.sv
// AXI-Stream bundle between a stream source and the checker sink.
interface axis_stream_checker_if #(
    parameter int unsigned DATA_SIZE = 32
) ();
    logic [DATA_SIZE-1:0]   tdata;
    logic [DATA_SIZE/8-1:0] tstrb;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_stream_checker.sv
// AXI-Stream sink checking incrementing data, fixed packet length and full strobes,
// with optional periodic tready backpressure.
module axis_stream_checker #(
    parameter int unsigned          DATA_SIZE    = 32,
    parameter int unsigned          PKT_LEN      = 16,
    parameter logic [DATA_SIZE-1:0] START_VALUE  = '0,
    parameter int unsigned          STALL_PERIOD = 0
) (
    input  logic                    s00_axis_aclk,
    input  logic                    s00_axis_areset,
    input  logic                    enable,
    input  logic                    clear,
    axis_stream_checker_if.slave    s00_axis,
    output logic [31:0]             beat_count,
    output logic [15:0]             pkt_count,
    output logic [15:0]             err_count,
    output logic                    err_flag,
    output logic [DATA_SIZE-1:0]    err_data,
    output logic [DATA_SIZE-1:0]    err_expected
);

    localparam int unsigned IDX_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int unsigned STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD + 1) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(PKT_LEN - 1);
    localparam logic [STALL_W-1:0] STALL_LAST =
        STALL_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

    typedef enum logic [1:0] {StIdle, StRun, StStall} state_e;

    state_e               state_q, state_d;
    logic                 tready_q, tready_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [31:0]          beat_count_q, beat_count_d;
    logic [15:0]          pkt_count_q, pkt_count_d;
    logic [15:0]          err_count_q, err_count_d;
    logic                 err_flag_q, err_flag_d;
    logic [DATA_SIZE-1:0] err_data_q, err_data_d;
    logic [DATA_SIZE-1:0] err_expected_q, err_expected_d;
    logic [DATA_SIZE-1:0] expected_q, expected_d;
    logic [IDX_W-1:0]     beat_idx_q, beat_idx_d;

    logic accept, beat_ok, stall_hit;
    logic idx_last, data_err, last_err, strb_err, any_err;

    // A beat accepted during clear is dropped, so it neither counts nor advances the stall timer.
    assign accept    = s00_axis.tvalid & tready_q;
    assign beat_ok   = accept & ~clear;
    assign stall_hit = (STALL_PERIOD != 0) && beat_ok && (stall_cnt_q == STALL_LAST);

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StRun;
            StRun: begin
                if (!enable)        state_d = StIdle;
                else if (stall_hit) state_d = StStall;
            end
            StStall: state_d = enable ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
        if (clear || stall_hit || state_q == StStall) begin
            stall_cnt_d = '0;
        end else if (beat_ok && STALL_PERIOD != 0) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        tready_d = (state_d == StRun);
    end

    assign idx_last = (beat_idx_q == IDX_LAST);
    assign data_err = (s00_axis.tdata != expected_q);
    assign last_err = (s00_axis.tlast != idx_last);
    assign strb_err = (s00_axis.tstrb != '1);
    assign any_err  = data_err | last_err | strb_err;

    always_comb begin
        beat_count_d   = beat_count_q;
        pkt_count_d    = pkt_count_q;
        err_count_d    = err_count_q;
        err_flag_d     = err_flag_q;
        err_data_d     = err_data_q;
        err_expected_d = err_expected_q;
        expected_d     = expected_q;
        beat_idx_d     = beat_idx_q;
        if (clear) begin
            beat_count_d   = '0;
            pkt_count_d    = '0;
            err_count_d    = '0;
            err_flag_d     = 1'b0;
            err_data_d     = '0;
            err_expected_d = '0;
            expected_d     = START_VALUE;
            beat_idx_d     = '0;
        end else if (accept) begin
            beat_count_d = beat_count_q + 32'd1;
            if (s00_axis.tlast) pkt_count_d = pkt_count_q + 16'd1;
            if (any_err) begin
                if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                if (!err_flag_q) begin
                    err_flag_d     = 1'b1;
                    err_data_d     = s00_axis.tdata;
                    err_expected_d = expected_q;
                end
            end
            // Resync on the received value so a single gap yields a single error.
            expected_d = s00_axis.tdata + 1'b1;
            beat_idx_d = (s00_axis.tlast || idx_last) ? '0 : beat_idx_q + 1'b1;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state_q        <= StIdle;
            tready_q       <= 1'b0;
            stall_cnt_q    <= '0;
            beat_count_q   <= '0;
            pkt_count_q    <= '0;
            err_count_q    <= '0;
            err_flag_q     <= 1'b0;
            err_data_q     <= '0;
            err_expected_q <= '0;
            expected_q     <= START_VALUE;
            beat_idx_q     <= '0;
        end else begin
            state_q        <= state_d;
            tready_q       <= tready_d;
            stall_cnt_q    <= stall_cnt_d;
            beat_count_q   <= beat_count_d;
            pkt_count_q    <= pkt_count_d;
            err_count_q    <= err_count_d;
            err_flag_q     <= err_flag_d;
            err_data_q     <= err_data_d;
            err_expected_q <= err_expected_d;
            expected_q     <= expected_d;
            beat_idx_q     <= beat_idx_d;
        end
    end

    assign s00_axis.tready = tready_q;
    assign beat_count      = beat_count_q;
    assign pkt_count       = pkt_count_q;
    assign err_count       = err_count_q;
    assign err_flag        = err_flag_q;
    assign err_data        = err_data_q;
    assign err_expected    = err_expected_q;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Bench for axis_stream_checker: directed scenarios plus random traffic against a reference model.
module tb_axis_stream_checker;

    localparam int unsigned DW = 32;
    localparam int unsigned PL = 16;
    localparam int unsigned SP = 4;
    localparam logic [DW-1:0] SV = '0;

    logic clk = 1'b0;
    logic rst, enable, clear;
    logic [31:0]   beat_count;
    logic [15:0]   pkt_count, err_count;
    logic          err_flag;
    logic [DW-1:0] err_data, err_expected;

    always #5 clk = ~clk;

    axis_stream_checker_if #(.DATA_SIZE(DW)) s_if ();

    axis_stream_checker #(
        .DATA_SIZE(DW), .PKT_LEN(PL), .START_VALUE(SV), .STALL_PERIOD(SP)
    ) dut (
        .s00_axis_aclk  (clk),
        .s00_axis_areset(rst),
        .enable         (enable),
        .clear          (clear),
        .s00_axis       (s_if.slave),
        .beat_count     (beat_count),
        .pkt_count      (pkt_count),
        .err_count      (err_count),
        .err_flag       (err_flag),
        .err_data       (err_data),
        .err_expected   (err_expected)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic cmp_on = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: stream rules applied beat by beat.
    logic          m_ready;
    logic [31:0]   m_beat;
    logic [15:0]   m_pkt, m_err;
    logic          m_flag;
    logic [DW-1:0] m_edata, m_eexp, m_exp;
    int            m_idx, m_stall;

    always @(posedge clk) begin : model
        logic acc, trig, bad;
        if (rst) begin
            m_ready <= 1'b0; m_beat <= '0; m_pkt <= '0; m_err <= '0; m_flag <= 1'b0;
            m_edata <= '0; m_eexp <= '0; m_exp <= SV; m_idx <= 0; m_stall <= 0;
        end else begin
            acc  = s_if.tvalid && m_ready;
            trig = 1'b0;
            if (clear) begin
                m_beat <= '0; m_pkt <= '0; m_err <= '0; m_flag <= 1'b0;
                m_edata <= '0; m_eexp <= '0; m_exp <= SV; m_idx <= 0; m_stall <= 0;
            end else if (acc) begin
                m_beat <= m_beat + 1;
                if (s_if.tlast) m_pkt <= m_pkt + 1;
                bad = (s_if.tdata != m_exp) || (s_if.tlast != (m_idx == PL - 1))
                      || (s_if.tstrb != 4'hF);
                if (bad) begin
                    if (m_err != 16'hFFFF) m_err <= m_err + 1;
                    if (!m_flag) begin
                        m_flag <= 1'b1; m_edata <= s_if.tdata; m_eexp <= m_exp;
                    end
                end
                m_exp <= s_if.tdata + 1;
                m_idx <= (s_if.tlast || m_idx == PL - 1) ? 0 : m_idx + 1;
                if (m_stall + 1 == SP) begin
                    trig = 1'b1;
                    m_stall <= 0;
                end else begin
                    m_stall <= m_stall + 1;
                end
            end
            m_ready <= enable && !trig;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("tready", s_if.tready, m_ready);
            chk("beat_count", beat_count, m_beat);
            chk("pkt_count", pkt_count, m_pkt);
            chk("err_count", err_count, m_err);
            chk("err_flag", err_flag, m_flag);
            chk("err_data", err_data, m_edata);
            chk("err_expected", err_expected, m_eexp);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tstrb  = '1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic send(logic [DW-1:0] d, logic l);
        logic rdy;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tstrb  = '1;
        rdy = 1'b0;
        for (int i = 0; i < 50 && !rdy; i++) begin
            @(negedge clk);
            rdy = s_if.tready;
            @(posedge clk);
            #1;
        end
        chk("handshake", rdy, 1'b1);
        idle();
    endtask

    initial begin
        int acc_n, stall_n;
        logic [DW-1:0] nxt;
        int pos;
        logic acc;

        rst = 1'b1; enable = 1'b0; clear = 1'b0;
        s_if.tdata = '0;
        idle();
        tick(2);
        cmp_on = 1'b1;
        chk("reset_tready", s_if.tready, 1'b0);
        chk("reset_beats", beat_count, 0);
        chk("reset_err_expected", err_expected, 0);

        // Two clean packets back to back.
        enable = 1'b1;
        do_reset();
        for (int d = 0; d < 32; d++) send(d, (d % 16) == 15);
        chk("t1_beats", beat_count, 32);
        chk("t1_pkts", pkt_count, 2);
        chk("t1_errs", err_count, 0);
        chk("t1_flag", err_flag, 0);

        // One data gap: single error, then resync.
        pulse_clear();
        for (int d = 0; d < 5; d++) send(d, 1'b0);
        send(6, 1'b0);
        send(7, 1'b0);
        chk("t2_errs", err_count, 1);
        chk("t2_err_data", err_data, 6);
        chk("t2_err_expected", err_expected, 5);

        // Early tlast, then a clean packet.
        pulse_clear();
        for (int d = 0; d <= 10; d++) send(d, d == 10);
        for (int d = 11; d <= 26; d++) send(d, d == 26);
        chk("t3_errs", err_count, 1);
        chk("t3_pkts", pkt_count, 2);

        // Backpressure with tvalid held high over 20 cycles.
        do_reset();
        tick(1);
        acc_n = 0; stall_n = 0; nxt = 0;
        for (int c = 0; c < 20; c++) begin
            s_if.tvalid = 1'b1; s_if.tdata = nxt; s_if.tlast = (nxt % 16) == 15;
            @(negedge clk);
            acc = s_if.tready;
            if (acc) acc_n++; else stall_n++;
            @(posedge clk);
            #1;
            if (acc) nxt = nxt + 1;
        end
        idle();
        chk("t4_accepts", acc_n, 16);
        chk("t4_stalls", stall_n, 4);
        chk("t4_pkts", pkt_count, 1);

        // Reset in the middle of a packet.
        do_reset();
        for (int d = 0; d < 7; d++) send(d, 1'b0);
        s_if.tvalid = 1'b1; s_if.tdata = 7; rst = 1'b1;
        tick(1);
        rst = 1'b0;
        idle();
        chk("t5_tready", s_if.tready, 0);
        chk("t5_beats", beat_count, 0);
        chk("t5_flag", err_flag, 0);
        tick(1);
        for (int d = 0; d < 16; d++) send(d, d == 15);
        chk("t5_errs", err_count, 0);
        chk("t5_pkts", pkt_count, 1);

        // Disabled sink and clear after an error.
        enable = 1'b0;
        tick(1);
        s_if.tvalid = 1'b1; s_if.tdata = 16;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t6_tready_low", s_if.tready, 0);
            tick(1);
        end
        idle();
        chk("t6_beats_frozen", beat_count, 16);
        enable = 1'b1;
        tick(1);
        send(99, 1'b0);
        chk("t6_flag_set", err_flag, 1);
        pulse_clear();
        chk("t6_flag_cleared", err_flag, 0);
        chk("t6_errs_cleared", err_count, 0);

        // Random traffic with occasional gaps, bad tlast/tstrb, enable drops, clears and resets.
        do_reset();
        nxt = 0; pos = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = s_if.tvalid && s_if.tready;
            @(posedge clk);
            #1;
            if (acc) begin
                nxt = s_if.tdata + 1;
                pos = s_if.tlast ? 0 : pos + 1;
            end
            rst    = ($urandom % 400) == 0;
            clear  = ($urandom % 80) == 0;
            enable = ($urandom % 25) != 0;
            s_if.tvalid = ($urandom % 5) != 0;
            if (($urandom % 20) == 0) nxt = nxt + $urandom_range(1, 5);
            s_if.tdata = nxt;
            s_if.tlast = (pos >= PL - 1) ^ (($urandom % 30) == 0);
            s_if.tstrb = (($urandom % 30) == 0) ? 4'($urandom) : 4'hF;
        end
        rst = 1'b0; clear = 1'b0;
        idle();
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
